// File: rtl/usbfs_debug_pkg.sv
// usbfs_debug_pkg
// Definitions shared by the debug UART transmitter and receiver:
//   - rx_state_t     : receiver FSM state encoding
//   - UART_DATA_BITS : data bits per 8N1 frame
//   - DEFAULT_CLK_DIV: default clk cycles per bit, common to RX and TX
package usbfs_debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int DEFAULT_CLK_DIV = 434;

endpackage

// File: rtl/usbfs_debug_rx_fifo.sv
// usbfs_debug_rx_fifo
// Pointer-based receive FIFO of 2^ASIZE entries with a registered head read.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   push       : write push_data this cycle (dropped if full)
//   push_data  : byte to store
//   rx_rdy     : consumer ready; a pop happens on rx_valid & rx_rdy
//   rx_data    : registered FIFO head
//   rx_valid   : FIFO non-empty (registered)
//   overflow   : one-cycle pulse when a push was dropped because full
module usbfs_debug_rx_fifo #(
  parameter int ASIZE  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              rx_rdy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ASIZE;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ASIZE:0]    wptr;
  logic [ASIZE:0]    rptr;
  logic [ASIZE:0]    rptr_n;
  logic              full;
  logic              wr_en;
  logic              pop;

  // Full ignores a same-cycle pop, so a stored byte is never overwritten.
  assign full   = (wptr ^ rptr) == {1'b1, {ASIZE{1'b0}}};
  assign wr_en  = push & ~full;
  assign pop    = rx_valid & rx_rdy;
  assign rptr_n = pop ? rptr + 1'b1 : rptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ASIZE-1:0]] <= push_data;
  end

  // Head and valid look at the post-pop read pointer so that a popped entry
  // is never presented twice; a write lands one cycle before it is visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      rptr     <= rptr_n;
      rx_data  <= mem[rptr_n[ASIZE-1:0]];
      rx_valid <= (wptr != rptr_n);
      overflow <= push & full;
    end
  end

endmodule

// File: rtl/usbfs_debug_uart_rx.sv
// usbfs_debug_uart_rx
// 8N1 UART receiver feeding a small byte FIFO drained on valid/ready.
// Optional macro USBFS_DEBUG_UART_RX_FERR_EN enables stop-bit checking:
// bad frames are dropped, frame_err pulses and the FSM waits for the line
// to return high. Without it every frame is pushed and frame_err is 0.
// Ports:
//   rstn      : asynchronous active-low reset
//   clk       : clock
//   i_uart_rx : asynchronous serial input, idle high
//   rx_data   : byte at FIFO head, valid while rx_valid
//   rx_valid  : FIFO non-empty
//   rx_rdy    : consumer accepts rx_data on rx_valid & rx_rdy
//   overflow  : one-cycle pulse, completed byte dropped (FIFO full)
//   frame_err : one-cycle pulse, bad stop bit
module usbfs_debug_uart_rx
  import usbfs_debug_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int ASIZE   = 4
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       i_uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rdy,
  output logic       overflow,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic             rx_meta_p0;
  logic             rx_sync_p1;
  logic             rx_prev_p2;
  logic [1:0]       fill;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push;
  logic             start_edge;

  // ---- stage p0/p1: synchroniser, stage p2: previous synced sample ----
  // The synchroniser resets high, which is not a real line observation.
  // fill holds the previous-sample register at 0 until two genuine samples
  // have flushed through, so a line held low across reset cannot look like
  // a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b0;
      fill       <= 2'b00;
    end else begin
      rx_meta_p0 <= i_uart_rx;
      rx_sync_p1 <= rx_meta_p0;
      fill       <= {fill[0], 1'b1};
      rx_prev_p2 <= fill[1] & rx_sync_p1;
    end
  end

  assign start_edge = rx_prev_p2 & ~rx_sync_p1;

  // ---- frame FSM ----
`ifdef USBFS_DEBUG_UART_RX_FERR_EN
  logic ferr;
  assign frame_err = ferr;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      push    <= 1'b0;
`ifdef USBFS_DEBUG_UART_RX_FERR_EN
      ferr    <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
`ifdef USBFS_DEBUG_UART_RX_FERR_EN
      ferr <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_sync_p1) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
`ifdef USBFS_DEBUG_UART_RX_FERR_EN
            if (!rx_sync_p1) begin
              ferr  <= 1'b1;
              state <= WAIT_HIGH;
            end else begin
              push  <= 1'b1;
              state <= IDLE;
            end
`else
            push  <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef USBFS_DEBUG_UART_RX_FERR_EN
        WAIT_HIGH: begin
          if (rx_sync_p1) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Shift register is pure data; it stays stable from bit 7 until the push.
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == CNT_FULL) shreg[bit_idx] <= rx_sync_p1;
  end

  // ---- receive FIFO ----
  usbfs_debug_rx_fifo #(
    .ASIZE  (ASIZE),
    .DATA_W (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (shreg),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_usbfs_debug_uart_rx.sv
module tb_usbfs_debug_uart_rx;

  localparam int CLK_DIV = 8;
  localparam int ASIZE   = 2;
  localparam int DEPTH   = 2 ** ASIZE;
  // line fall -> 2 sync flops + edge detect, half bit, 8 data bits,
  // stop bit, then push cycle and registered head read
  localparam int LAT_VALID = 3 + CLK_DIV / 2 + 8 * CLK_DIV + CLK_DIV + 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overflow;
  logic       frame_err;

  usbfs_debug_uart_rx #(
    .CLK_DIV (CLK_DIV),
    .ASIZE   (ASIZE)
  ) dut (
    .rstn      (rstn),
    .clk       (clk),
    .i_uart_rx (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_rdy    (rx_rdy),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic, collected on the falling edge.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   ovf_cnt = 0;
  int   ferr_cnt = 0;
  int   rise_cyc = 0;
  logic mon_prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_valid && rx_rdy) got_q.push_back(rx_data);
      if (overflow)  ovf_cnt  <= ovf_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_valid && !mon_prev_valid) rise_cyc <= cyc;
    end
    mon_prev_valid <= rx_valid;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int start_cyc = 0;

  // One 8N1 frame, LSB first, line left high afterwards.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    uart_rx = 1'b0;
    wait_cyc(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(CLK_DIV);
    end
    uart_rx = stop_bit;
    wait_cyc(CLK_DIV);
    uart_rx = 1'b1;
  endtask

  // Compare everything received against the reference stream.
  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(tag, (i < got_q.size()) ? int'(got_q[i]) : -1, int'(exp_q[i]));
    end
  endtask

  int   ovf0, ferr0;
  logic done;
  logic [7:0] b;

  initial begin
    // reset with the line held low throughout
    uart_rx = 1'b0;
    wait_cyc(3);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_ferr", frame_err, 0);
    rstn = 1'b1;
    wait_cyc(30);
    uart_rx = 1'b1;
    wait_cyc(20);
    chk("low_through_reset", got_q.size() + (rx_valid ? 1 : 0), 0);

    // single frame, latency and clean flags
    rx_rdy = 1'b1;
    got_q.delete(); exp_q.delete();
    ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    send_byte(8'h55, 1'b1);
    wait_cyc(2 * CLK_DIV);
    exp_q.push_back(8'h55);
    cmp_stream("t1_byte");
    chk("t1_latency", rise_cyc - start_cyc, LAT_VALID);
    chk("t1_ovf", ovf_cnt - ovf0, 0);
    chk("t1_ferr", ferr_cnt - ferr0, 0);

    // buffered back-to-back bytes, then drain
    rx_rdy = 1'b0;
    got_q.delete(); exp_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_cyc(CLK_DIV);
    chk("t2_hold_valid", rx_valid, 1);
    chk("t2_hold_data", rx_data, 8'hA5);
    rx_rdy = 1'b1;
    wait_cyc(10);
    exp_q = '{8'hA5, 8'h3C, 8'h00};
    cmp_stream("t2_drain");
    chk("t2_empty", rx_valid, 0);

    // overflow: one more byte than the FIFO holds
    rx_rdy = 1'b0;
    got_q.delete(); exp_q.delete();
    ovf0 = ovf_cnt;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_byte(8'(i), 1'b1);
      if (i <= DEPTH) exp_q.push_back(8'(i));
    end
    wait_cyc(CLK_DIV);
    chk("t3_ovf_pulses", ovf_cnt - ovf0, 1);
    rx_rdy = 1'b1;
    wait_cyc(10);
    cmp_stream("t3_drain");
    chk("t3_empty", rx_valid, 0);

    // start-bit glitch shorter than half a bit
    got_q.delete(); exp_q.delete();
    uart_rx = 1'b0;
    wait_cyc(3);
    uart_rx = 1'b1;
    wait_cyc(20);
    chk("t4_glitch_nopush", got_q.size() + (rx_valid ? 1 : 0), 0);
    send_byte(8'hC3, 1'b1);
    wait_cyc(2 * CLK_DIV);
    exp_q.push_back(8'hC3);
    cmp_stream("t4_after_glitch");

    // bad stop bit, line kept low for a while afterwards
    got_q.delete(); exp_q.delete();
    ferr0 = ferr_cnt;
    send_byte(8'h7E, 1'b0);
    uart_rx = 1'b0;
    wait_cyc(2 * CLK_DIV);
`ifdef USBFS_DEBUG_UART_RX_FERR_EN
    chk("t5_ferr_pulses", ferr_cnt - ferr0, 1);
    chk("t5_no_push", got_q.size() + (rx_valid ? 1 : 0), 0);
`else
    chk("t5_ferr_pulses", ferr_cnt - ferr0, 0);
    exp_q.push_back(8'h7E);
`endif
    uart_rx = 1'b1;
    wait_cyc(20);
    send_byte(8'h11, 1'b1);
    wait_cyc(2 * CLK_DIV);
    exp_q.push_back(8'h11);
    cmp_stream("t5_stream");

    // reset in the middle of a frame with a byte buffered
    rx_rdy = 1'b0;
    got_q.delete(); exp_q.delete();
    send_byte(8'h33, 1'b1);
    wait_cyc(CLK_DIV);
    chk("t6_buffered", rx_valid, 1);
    uart_rx = 1'b0;
    wait_cyc(CLK_DIV * 5);
    rstn = 1'b0;
    #1;
    chk("t6_async_clear", rx_valid, 0);
    wait_cyc(4);
    rstn = 1'b1;
    wait_cyc(10);
    uart_rx = 1'b1;
    wait_cyc(20);
    rx_rdy = 1'b1;
    send_byte(8'h9A, 1'b1);
    wait_cyc(2 * CLK_DIV);
    exp_q.push_back(8'h9A);
    cmp_stream("t6_after_reset");

    // random bytes, random gaps, random consumer readiness
    got_q.delete(); exp_q.delete();
    ovf0 = ovf_cnt;
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      done = 1'b0;
      fork
        begin
          send_byte(b, 1'b1);
          wait_cyc($urandom_range(0, 10));
          done = 1'b1;
        end
        begin
          while (!done) begin
            rx_rdy = 1'($urandom);
            wait_cyc(1);
          end
        end
      join
    end
    rx_rdy = 1'b1;
    wait_cyc(3 * CLK_DIV);
    cmp_stream("rand");
    chk("rand_ovf", ovf_cnt - ovf0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
